// File: rtl/result_arbiter_pkg.sv
// Shared types for the result/commit merger: the Result message layout,
// its width, a kind extractor and the arbiter lock state.
package result_arbiter_pkg;

    typedef struct packed {
        logic [7:0]  commit_id;
        logic        kind;       // 1 = branch result
        logic [47:0] payload;
    } Result;

    localparam int RESULT_W = $bits(Result);

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic logic msg_kind(input logic [RESULT_W-1:0] m);
        return m[RESULT_W-9];
    endfunction

endpackage

// File: rtl/result_arbiter_if.sv
// Bundle of the N input en/reject channels and the single output channel.
// The arb modport is the merger side; env is the execution-unit/commit side.
interface result_arbiter_if
    import result_arbiter_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int MSG_W = RESULT_W
) ();

    logic [N_CH-1:0]            in_en;
    logic [N_CH-1:0][MSG_W-1:0] in_msg;
    logic [N_CH-1:0]            in_reject;
    logic                       out_en;
    logic [MSG_W-1:0]           out_msg;
    logic                       out_reject;

    modport arb (
        input  in_en, in_msg, out_reject,
        output in_reject, out_en, out_msg
    );

    modport env (
        output in_en, in_msg, out_reject,
        input  in_reject, out_en, out_msg
    );

endinterface

// File: rtl/result_arbiter_fifo.sv
// msg_fifo: small per-channel message buffer. Pointers wrap naturally;
// the count carries one extra bit so full and empty are distinguishable.
module msg_fifo #(
    parameter int DEPTH = 2,
    parameter int MSG_W = 57
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [MSG_W-1:0] msg_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [MSG_W-1:0] head_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][MSG_W-1:0] mem_q;
    logic [PW-1:0]               hd_q, hd_d, tl_q, tl_d;
    logic [PW:0]                 cnt_q, cnt_d;
    logic                        do_push, do_pop;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[hd_q];

    // Full refuses a push even when the same cycle pops: no pass-through.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        hd_d  = hd_q;
        tl_d  = tl_q;
        cnt_d = cnt_q;
        if (do_push) tl_d = tl_q + PW'(1);
        if (do_pop)  hd_d = hd_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (PW+1)'(1);
            2'b01:   cnt_d = cnt_q - (PW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            hd_q  <= '0;
            tl_q  <= '0;
            cnt_q <= '0;
        end else begin
            hd_q  <= hd_d;
            tl_q  <= tl_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[tl_q] <= msg_i;
    end

endmodule

// File: rtl/result_arbiter.sv
// result_arbiter: N-to-1 round-robin merger of per-channel result FIFOs.
// Optional macro RESULT_ARB_BRANCH_FIRST_EN gives branch heads priority.
module result_arbiter
    import result_arbiter_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int DEPTH = 2,
    parameter int MSG_W = RESULT_W
) (
    input logic            clk,
    input logic            nreset,
    result_arbiter_if.arb  bus
);

    localparam int CH_W = $clog2(N_CH);

    logic [N_CH-1:0]            full, empty, push, pop, cand;
    logic [N_CH-1:0][MSG_W-1:0] head;
    logic [CH_W-1:0]            rr_q, rr_d, gnt_q, gnt_d, grant, rr_gnt;
    arb_state_e                 state_q, state_d;
    logic                       any, accept;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        msg_fifo #(.DEPTH(DEPTH), .MSG_W(MSG_W)) u_fifo (
            .clk     (clk),
            .nreset  (nreset),
            .push_i  (push[c]),
            .pop_i   (pop[c]),
            .msg_i   (bus.in_msg[c]),
            .full_o  (full[c]),
            .empty_o (empty[c]),
            .head_o  (head[c])
        );
        assign push[c] = bus.in_en[c] & ~full[c];
        assign pop[c]  = accept & (grant == CH_W'(c));
    end

    assign bus.in_reject = full;
    assign any           = |(~empty);

`ifdef RESULT_ARB_BRANCH_FIRST_EN
    logic [N_CH-1:0] kind, br_heads;
    for (genvar c = 0; c < N_CH; c++) begin : g_kind
        assign kind[c] = head[c][MSG_W-9];
    end
    assign br_heads = ~empty & kind;
    assign cand     = (|br_heads) ? br_heads : ~empty;
`else
    assign cand = ~empty;
`endif

    // Scan from the farthest offset down so the closest hit at or after rr wins.
    always_comb begin
        int              ix;
        logic [CH_W-1:0] ixw;
        rr_gnt = rr_q;
        ix     = 0;
        ixw    = '0;
        for (int o = N_CH - 1; o >= 0; o--) begin
            ix  = (int'(rr_q) + o) % N_CH;
            ixw = CH_W'(ix);
            if (cand[ixw]) rr_gnt = ixw;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        grant   = (state_q == ARB_LOCKED) ? gnt_q : rr_gnt;
        accept  = any & ~bus.out_reject;
        if (any && bus.out_reject) begin
            state_d = ARB_LOCKED;
            gnt_d   = grant;
        end else begin
            state_d = ARB_FREE;
        end
        if (accept) rr_d = (grant == CH_W'(N_CH - 1)) ? '0 : grant + CH_W'(1);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ARB_FREE;
            gnt_q   <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.out_en  = any;
    assign bus.out_msg = any ? head[grant] : '0;

endmodule
